// File: rtl/lod_pkg.sv
// Shared leading-one-detector types and helpers for the log multiplier and antilog stage.
package lod_pkg;

    function automatic int unsigned lod_k_w(input int unsigned width);
        return int'($clog2(width));
    endfunction

    localparam int unsigned LOD_WIDTH  = 16;
    localparam int unsigned LOD_K_W    = lod_k_w(LOD_WIDTH);
    localparam int unsigned LOD_FRAC_W = LOD_WIDTH - 1;

    typedef struct packed {
        logic                  zero;
        logic [LOD_K_W-1:0]    k;
        logic [LOD_FRAC_W-1:0] frac;
        logic                  sign;
    } lod_res_t;

endpackage

// File: rtl/lod_pipe_if.sv
// Operand/result handshake bundle for lod_pipe; out_sign exists only with LOD_SIGNED_EN.
interface lod_pipe_if
    import lod_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned K_W    = lod_k_w(WIDTH);
    localparam int unsigned FRAC_W = WIDTH - 1;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_zero;
    logic [K_W-1:0]    out_k;
    logic [FRAC_W-1:0] out_frac;
`ifdef LOD_SIGNED_EN
    logic              out_sign;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_zero, out_k, out_frac, out_sign);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_zero, out_k, out_frac, out_sign);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_zero, out_k, out_frac);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_zero, out_k, out_frac);
`endif
endinterface

// File: rtl/lod_prienc.sv
// Combinational priority encoder: index of the highest set bit, plus zero flag.
module lod_prienc
    import lod_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned K_W   = lod_k_w(WIDTH)
) (
    input  logic [WIDTH-1:0] mag,
    output logic [K_W-1:0]   k,
    output logic             zero
);

    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) k = K_W'(i);
        end
        zero = ~|mag;
    end

endmodule

// File: rtl/lod_pipe.sv
// Two-stage pipelined leading-one detector with valid/ready backpressure.
// Define LOD_SIGNED_EN for two's-complement operands (magnitude + out_sign).
module lod_pipe
    import lod_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    lod_pipe_if.slave  bus
);

    localparam int unsigned K_W    = lod_k_w(WIDTH);
    localparam int unsigned FRAC_W = WIDTH - 1;

    logic              s1_valid, s2_valid;
    logic              s1_load, s2_load, in_fire;
    logic [WIDTH-1:0]  mag;
    logic [K_W-1:0]    k_c;
    logic              zero_c;
    logic [WIDTH-1:0]  s1_mag;
    logic [K_W-1:0]    s1_k;
    logic              s1_zero;
    logic [WIDTH-1:0]  shifted;
    logic [K_W-1:0]    s2_k;
    logic              s2_zero;
    logic [FRAC_W-1:0] s2_frac;

    assign s2_load = !s2_valid | bus.out_ready;
    assign s1_load = !s1_valid | s2_load;
    assign in_fire = bus.in_valid & s1_load;

`ifdef LOD_SIGNED_EN
    logic s1_sign, s2_sign;
    assign mag = bus.in_data[WIDTH-1] ? WIDTH'(-bus.in_data) : bus.in_data;
`else
    assign mag = bus.in_data;
`endif

    lod_prienc #(.WIDTH(WIDTH)) u_prienc (
        .mag  (mag),
        .k    (k_c),
        .zero (zero_c)
    );

    // S1: capture magnitude and encoded position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_k     <= '0;
            s1_zero  <= 1'b0;
`ifdef LOD_SIGNED_EN
            s1_sign  <= 1'b0;
`endif
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_mag  <= mag;
                s1_k    <= k_c;
                s1_zero <= zero_c;
`ifdef LOD_SIGNED_EN
                s1_sign <= bus.in_data[WIDTH-1];
`endif
            end
        end
    end

    // Left-align the bits below the leading one; a zero magnitude stays zero
    assign shifted = s1_mag << (K_W'(WIDTH - 1) - s1_k);

    // S2: result registers driving the output bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_k     <= '0;
            s2_zero  <= 1'b0;
            s2_frac  <= '0;
`ifdef LOD_SIGNED_EN
            s2_sign  <= 1'b0;
`endif
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_k    <= s1_k;
                s2_zero <= s1_zero;
                s2_frac <= shifted[FRAC_W-1:0];
`ifdef LOD_SIGNED_EN
                s2_sign <= s1_sign;
`endif
            end
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_k     = s2_k;
    assign bus.out_zero  = s2_zero;
    assign bus.out_frac  = s2_frac;
`ifdef LOD_SIGNED_EN
    assign bus.out_sign  = s2_sign;
`endif

endmodule

// File: tb/tb_lod_pipe.sv
// Self-checking bench for lod_pipe (WIDTH=16): directed vectors plus randomized
// traffic against an arithmetic reference model with a FIFO scoreboard.
module tb_lod_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned KW = 4;
    localparam int unsigned FW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lod_pipe_if #(.WIDTH(W)) bus ();

    lod_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic obs_sign;
`ifdef LOD_SIGNED_EN
    assign obs_sign = bus.out_sign;
`else
    assign obs_sign = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]  data;
        logic [KW-1:0] k;
        logic [FW-1:0] frac;
        logic          zero;
        logic          sign;
        int            cyc;
    } item_t;

    item_t src[$];
    item_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    bit chk_lat  = 1'b0;
    bit rnd_valid = 1'b0;
    bit rnd_ready = 1'b0;

    bit            held_v = 1'b0;
    logic [KW-1:0] h_k;
    logic [FW-1:0] h_frac;
    logic          h_zero;
    logic          h_sign;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Reference: magnitude, highest power of two not above it, remainder scaled to 15 bits
    function automatic item_t model(input logic [W-1:0] d);
        item_t it;
        int    m;
        int    k;
        m = int'(d);
`ifdef LOD_SIGNED_EN
        if (d[W-1]) m = 65536 - int'(d);
        it.sign = d[W-1];
`else
        it.sign = 1'b0;
`endif
        it.data = d;
        it.cyc  = 0;
        if (m == 0) begin
            it.zero = 1'b1;
            it.k    = '0;
            it.frac = '0;
        end else begin
            k = 0;
            while ((2 ** (k + 1)) <= m) k++;
            it.zero = 1'b0;
            it.k    = KW'(k);
            it.frac = FW'((m - 2 ** k) * (2 ** (15 - k)));
        end
        return it;
    endfunction

    task automatic add_dir(input logic [W-1:0] d, input int k, input int frac,
                           input bit z, input bit s);
        item_t it;
        it.data = d; it.k = KW'(k); it.frac = FW'(frac);
        it.zero = z; it.sign = s; it.cyc = 0;
        src.push_back(it);
    endtask

    task automatic add_rnd(input logic [W-1:0] d);
        src.push_back(model(d));
    endtask

    function automatic logic [W-1:0] rnd_data();
        case ($urandom_range(4))
            0:       return W'($urandom);
            1:       return W'(1) << $urandom_range(15);
            2:       return W'($urandom_range(3));
            3:       return 16'h8000;
            default: return W'($urandom) >> $urandom_range(15);
        endcase
    endfunction

    // One clock: drive at start, evaluate handshakes before the edge, advance
    task automatic cycle();
        item_t it;
        item_t e;
        bus.in_valid = (src.size() != 0) && (!rnd_valid || $urandom_range(3) != 0);
        bus.in_data  = (src.size() != 0) ? src[0].data : '0;
        @(negedge clk);
        if (held_v) begin
            check("hold_valid", 32'(bus.out_valid), 32'(1));
            check("hold_k",     32'(bus.out_k),     32'(h_k));
            check("hold_frac",  32'(bus.out_frac),  32'(h_frac));
            check("hold_zero",  32'(bus.out_zero),  32'(h_zero));
            check("hold_sign",  32'(obs_sign),      32'(h_sign));
        end
        held_v = bus.out_valid && !bus.out_ready;
        h_k = bus.out_k; h_frac = bus.out_frac; h_zero = bus.out_zero; h_sign = obs_sign;
        if (bus.in_valid && bus.in_ready) begin
            it = src.pop_front();
            it.cyc = cyc;
            exp_q.push_back(it);
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_k",    32'(bus.out_k),    32'(e.k));
                check("out_frac", 32'(bus.out_frac), 32'(e.frac));
                check("out_zero", 32'(bus.out_zero), 32'(e.zero));
                check("out_sign", 32'(obs_sign),     32'(e.sign));
                if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'(2));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && n < budget) begin
            if (rnd_ready) bus.out_ready = 1'($urandom_range(1));
            cycle();
            n++;
        end
        check("drain_timeout", 32'(src.size() + exp_q.size()), 32'(0));
    endtask

    initial begin
        int acc0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_k",     32'(bus.out_k),     32'(0));
        check("rst_out_frac",  32'(bus.out_frac),  32'(0));
        check("rst_out_zero",  32'(bus.out_zero),  32'(0));
        check("rst_out_sign",  32'(obs_sign),      32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));

        // Single operand with latency 2
        chk_lat = 1'b1;
        add_dir(16'h00B4, 7, 'h3400, 1'b0, 1'b0);
        drain(20);

        // Boundary operands
        add_dir(16'h0000, 0, 0, 1'b1, 1'b0);
        add_dir(16'h0001, 0, 0, 1'b0, 1'b0);
        add_dir(16'h8000, 15, 0, 1'b0, `ifdef LOD_SIGNED_EN 1'b1 `else 1'b0 `endif);
        drain(20);

        // Back-to-back, full throughput
        add_dir(16'h0003, 1, 'h4000, 1'b0, 1'b0);
        add_dir(16'h0100, 8, 0, 1'b0, 1'b0);
`ifdef LOD_SIGNED_EN
        add_dir(16'hFFFF, 0, 0, 1'b0, 1'b1);
        add_dir(16'hFF4C, 7, 'h3400, 1'b0, 1'b1);
`else
        add_dir(16'hFFFF, 15, 'h7FFF, 1'b0, 1'b0);
`endif
        drain(20);

        // Backpressure: 6 stalled cycles offering 4 operands
        chk_lat = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) add_rnd(rnd_data());
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) cycle();
        check("stall_accepted", 32'(n_acc - acc0), 32'(2));
        check("stall_in_ready", 32'(bus.in_ready), 32'(0));
        check("stall_out_valid", 32'(bus.out_valid), 32'(1));
        bus.out_ready = 1'b1;
        drain(40);

        // Reset with two operands in flight
        chk_lat = 1'b1;
        add_rnd(16'h0123);
        add_rnd(16'h4000);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        check("midrst_out_k",     32'(bus.out_k),     32'(0));
        check("midrst_out_frac",  32'(bus.out_frac),  32'(0));
        check("midrst_in_ready",  32'(bus.in_ready),  32'(1));
        src.delete();
        exp_q.delete();
        held_v = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_rst_idle", 32'(bus.out_valid), 32'(0));
        end
        add_rnd(16'h0B00);
        drain(20);

        // Random traffic with random backpressure
        chk_lat   = 1'b0;
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) add_rnd(rnd_data());
        drain(2000);

        // Random traffic at full output rate, latency enforced
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 60; i++) add_rnd(rnd_data());
        drain(600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
